// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C master sequencer.
package i2c_pkg;
  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } i2c_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_RESP
  } i2c_state_e;

  localparam int PHASES_PER_BIT = 4;
  localparam int BITS_PER_BYTE  = 9;
endpackage

// File: rtl/i2c_phase_tick.sv
// Quarter-bit phase generator: ticks every CLK_DIV cycles, freezes while the slave stretches SCL.
module i2c_phase_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] phase
);
  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST) && !hold;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt   <= '0;
      phase <= '0;
    end else if (!hold) begin
      if (tick) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end
endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: sequences START / WRITE / READ / STOP onto SCL/SDA, one response per command.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] wdata_i,
  input  logic       rd_nack_i,
  output logic       rsp_valid_o,
  output logic [7:0] rdata_o,
  output logic       ack_o,
  output logic       err_o,
  output logic       busy_o,
  output logic       scl_o,
  input  logic       scl_i,
  output logic       sda_t_o,
  input  logic       sda_i
);
  i2c_state_e state, state_n;
  i2c_cmd_e   cmd_in, cmd_q;
  logic [7:0] wdata_q, rdata_q;
  logic [8:0] sh;
  logic [3:0] bit_idx;
  logic [2:0] data_sel;
  logic       nack_q, busy_q, err_q, ack_q;
  logic       scl_hold, sda_hold, scl_c, sda_c, data_bit;
  logic       tick, clr, hold, accept, active, last_phase;
  logic [1:0] phase;

  i2c_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (clr),
    .hold  (hold),
    .tick  (tick),
    .phase (phase)
  );

  assign cmd_in      = i2c_cmd_e'(cmd_i);
  assign cmd_ready_o = (state == ST_IDLE) || (state == ST_RESP);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign active      = (state == ST_START) || (state == ST_BIT) || (state == ST_STOP);
  assign last_phase  = tick && (phase == 2'(PHASES_PER_BIT - 1));
  // Stretch: we release SCL high in P2 but the slave still pulls it low.
  assign hold        = active && (phase == 2'd2) && scl_c && !scl_i;

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    unique case (state)
      ST_IDLE, ST_RESP: begin
        if (state == ST_RESP) state_n = ST_IDLE;
        if (accept) begin
          clr = 1'b1;
          if (cmd_in == CMD_START)     state_n = ST_START;
          else if (!busy_q)            state_n = ST_RESP;
          else if (cmd_in == CMD_STOP) state_n = ST_STOP;
          else                         state_n = ST_BIT;
        end
      end
      ST_START, ST_STOP: if (last_phase) state_n = ST_RESP;
      ST_BIT:            if (last_phase && bit_idx == 4'd0) state_n = ST_RESP;
      default:           state_n = ST_IDLE;
    endcase
  end

  // Bit 0 is the ACK slot; data bits 8..1 map to wdata[7..0].
  assign data_sel = 3'(bit_idx - 4'd1);
  always_comb begin
    data_bit = 1'b1;
    if (bit_idx == 4'd0) data_bit = (cmd_q == CMD_READ) ? nack_q : 1'b1;
    else                 data_bit = (cmd_q == CMD_WRITE) ? wdata_q[data_sel] : 1'b1;
  end

  // Pins follow the phase table while active and otherwise hold their last level.
  always_comb begin
    scl_c = scl_hold;
    sda_c = sda_hold;
    unique case (state)
      ST_START: begin
        scl_c = (phase == 2'd1) || (phase == 2'd2);
        sda_c = !phase[1];
      end
      ST_BIT: begin
        scl_c = phase[1];
        sda_c = data_bit;
      end
      ST_STOP: begin
        scl_c = (phase != 2'd0);
        sda_c = phase[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      cmd_q    <= CMD_START;
      wdata_q  <= '0;
      nack_q   <= 1'b0;
      bit_idx  <= '0;
      sh       <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      scl_hold <= 1'b1;
      sda_hold <= 1'b1;
    end else begin
      state    <= state_n;
      scl_hold <= scl_c;
      sda_hold <= sda_c;
      if (accept) begin
        cmd_q   <= cmd_in;
        wdata_q <= wdata_i;
        nack_q  <= rd_nack_i;
        bit_idx <= 4'(BITS_PER_BYTE - 1);
        err_q   <= (cmd_in != CMD_START) && !busy_q;
      end
      if (state == ST_BIT && tick) begin
        if (phase == 2'd2) sh <= {sh[7:0], sda_i};
        if (phase == 2'd3 && bit_idx != 4'd0) bit_idx <= bit_idx - 4'd1;
      end
      if (last_phase) begin
        unique case (state)
          ST_START: busy_q <= 1'b1;
          ST_STOP:  busy_q <= 1'b0;
          ST_BIT: if (bit_idx == 4'd0) begin
            if (cmd_q == CMD_READ) rdata_q <= sh[8:1];
            else                   ack_q   <= !sh[0];
          end
          default: ;
        endcase
      end
    end
  end

  assign rsp_valid_o = (state == ST_RESP);
  assign rdata_o     = rdata_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign scl_o       = scl_c;
  assign sda_t_o     = sda_c;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed command table against a small open-drain slave model, plus reset and mid-byte-reset sequences.
module tb_i2c_master_ctrl;
  logic       clk = 1'b0, rst_ni = 1'b0, cmd_valid_i = 1'b0, rd_nack_i = 1'b0;
  logic [1:0] cmd_i = 2'd0;
  logic [7:0] wdata_i = 8'h00;
  logic       cmd_ready_o, rsp_valid_o, ack_o, err_o, busy_o, scl_o, sda_t_o, scl_i, sda_i;
  logic [7:0] rdata_o;

  logic       stretch_on = 1'b0, slave_sda = 1'b1;
  assign scl_i = scl_o & ~stretch_on;
  assign sda_i = sda_t_o & slave_sda;

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_i(cmd_i), .wdata_i(wdata_i), .rd_nack_i(rd_nack_i), .rsp_valid_o(rsp_valid_o),
    .rdata_o(rdata_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o), .scl_o(scl_o),
    .scl_i(scl_i), .sda_t_o(sda_t_o), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // monitor results of the last command
  int         lat, toggles, rises, idx, st_cnt;
  logic       start_seen, stop_seen, saw_rise, st_done, prev_scl, prev_sda;
  logic [8:0] mbits;
  logic       r_err, r_ack, r_busy;
  logic [7:0] r_rdata;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] wd, input logic nk,
                         input logic [7:0] sb, input logic sa, input logic st);
    logic s, d;
    int w = 0;
    @(negedge clk);
    while (!cmd_ready_o && w < 50) begin @(negedge clk); w++; end
    if (!cmd_ready_o) check("ready_timeout", 32'(cmd_ready_o), 32'd1);
    prev_scl = scl_o; prev_sda = sda_t_o;
    idx = 0; rises = 0; saw_rise = 0; toggles = 0; start_seen = 0; stop_seen = 0;
    mbits = '1; stretch_on = 0; st_cnt = 0; st_done = !st;
    slave_sda = (c == 2'd2) ? sb[7] : 1'b1;
    cmd_valid_i = 1; cmd_i = c; wdata_i = wd; rd_nack_i = nk;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      cmd_valid_i = 0;
      if (stretch_on) begin st_cnt--; if (st_cnt == 0) stretch_on = 0; end
      s = scl_o; d = sda_t_o;
      if (s != prev_scl || d != prev_sda) toggles++;
      if (prev_scl && s && prev_sda && !d) start_seen = 1;
      if (prev_scl && s && !prev_sda && d) stop_seen = 1;
      if (!prev_scl && s) begin
        saw_rise = 1;
        if (rises < 9) mbits[rises] = d;
        rises++;
        if (!st_done) begin stretch_on = 1; st_cnt = 20; st_done = 1; end
      end
      if (prev_scl && !s && saw_rise) idx++;
      prev_scl = s; prev_sda = d;
      if (c == 2'd2)      slave_sda = (idx < 8) ? sb[7-idx] : 1'b1;
      else if (c == 2'd1) slave_sda = (idx == 8) ? !sa : 1'b1;
      else                slave_sda = 1'b1;
      if (rsp_valid_o) begin
        lat = n; r_err = err_o; r_ack = ack_o; r_busy = busy_o; r_rdata = rdata_o;
        break;
      end
    end
    slave_sda = 1'b1; stretch_on = 0;
  endtask

  typedef struct {
    logic [1:0] cmd; logic [7:0] wdata; logic nack; logic [7:0] sbyte; logic sack; logic stretch;
    int lat; logic err; logic ack; logic [7:0] rdata; logic busy;
  } vec_t;
  vec_t vecs[12];

  initial begin
    logic [7:0] wb;
    //          cmd   wdata  nk sbyte  sa st  lat  err ack rdata  busy
    vecs[0]  = '{2'd3, 8'h00, 0, 8'h00, 0, 0,   1,  1,  0, 8'h00, 0};  // STOP idle
    vecs[1]  = '{2'd1, 8'h11, 0, 8'h00, 0, 0,   1,  1,  0, 8'h00, 0};  // WRITE idle
    vecs[2]  = '{2'd0, 8'h00, 0, 8'h00, 0, 0,  17,  0,  0, 8'h00, 1};
    vecs[3]  = '{2'd1, 8'hA5, 0, 8'h00, 1, 0, 145,  0,  1, 8'h00, 1};
    vecs[4]  = '{2'd2, 8'h00, 1, 8'h3C, 0, 0, 145,  0,  1, 8'h3C, 1};
    vecs[5]  = '{2'd0, 8'h00, 0, 8'h00, 0, 0,  17,  0,  1, 8'h3C, 1};  // repeated start
    vecs[6]  = '{2'd1, 8'h3C, 0, 8'h00, 0, 0, 145,  0,  0, 8'h3C, 1};  // slave NACK
    vecs[7]  = '{2'd1, 8'h96, 0, 8'h00, 1, 1, 165,  0,  1, 8'h3C, 1};  // stretched 20
    vecs[8]  = '{2'd2, 8'h00, 0, 8'h5A, 0, 0, 145,  0,  1, 8'h5A, 1};
    vecs[9]  = '{2'd3, 8'h00, 0, 8'h00, 0, 0,  17,  0,  1, 8'h5A, 0};
    vecs[10] = '{2'd2, 8'h00, 0, 8'h00, 0, 0,   1,  1,  1, 8'h5A, 0};  // READ idle
    vecs[11] = '{2'd0, 8'h00, 0, 8'h00, 0, 0,  17,  0,  1, 8'h5A, 1};

    // reset held 3 cycles, then idle outputs must be quiet
    repeat (3) @(posedge clk);
    @(negedge clk); rst_ni = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("rst_idle%0d", i), {27'd0, scl_o, sda_t_o, cmd_ready_o, busy_o, rsp_valid_o},
            {27'd0, 5'b11100});
    end

    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].cmd, vecs[i].wdata, vecs[i].nack, vecs[i].sbyte, vecs[i].sack, vecs[i].stretch);
      check($sformatf("v%0d_lat", i),   32'(lat),     32'(vecs[i].lat));
      check($sformatf("v%0d_err", i),   32'(r_err),   32'(vecs[i].err));
      check($sformatf("v%0d_ack", i),   32'(r_ack),   32'(vecs[i].ack));
      check($sformatf("v%0d_rdata", i), 32'(r_rdata), 32'(vecs[i].rdata));
      check($sformatf("v%0d_busy", i),  32'(r_busy),  32'(vecs[i].busy));
      if (vecs[i].err) check($sformatf("v%0d_quiet", i), 32'(toggles), 32'd0);
      else if (vecs[i].cmd == 2'd0) check($sformatf("v%0d_start_cond", i), 32'(start_seen), 32'd1);
      else if (vecs[i].cmd == 2'd3) check($sformatf("v%0d_stop_cond", i), 32'(stop_seen), 32'd1);
      else if (vecs[i].cmd == 2'd1) begin
        for (int b = 0; b < 8; b++) wb[7-b] = mbits[b];
        check($sformatf("v%0d_sda_bits", i), 32'(wb), 32'(vecs[i].wdata));
      end else check($sformatf("v%0d_ack_slot", i), 32'(mbits[8]), 32'(vecs[i].nack));
    end

    // reset pulse in P2 of bit 5 (4th SCL rise) of a WRITE
    begin
      int r = 0;
      logic p;
      @(negedge clk);
      cmd_valid_i = 1; cmd_i = 2'd1; wdata_i = 8'hC3; rd_nack_i = 0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid_i = 0;
      p = scl_o;
      for (int n = 0; n < 300 && r < 4; n++) begin
        @(negedge clk);
        if (!p && scl_o) r++;
        p = scl_o;
      end
      check("midrst_reach", 32'(r), 32'd4);
      rst_ni = 0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_outputs",
            {17'd0, scl_o, sda_t_o, cmd_ready_o, rsp_valid_o, busy_o, err_o, ack_o, rdata_o},
            {17'd0, 7'b1110000, 8'h00});
      rst_ni = 1;
    end
    run_cmd(2'd0, 8'h00, 0, 8'h00, 0, 0);
    check("post_rst_lat",  32'(lat), 32'd17);
    check("post_rst_busy", 32'(r_busy), 32'd1);
    check("post_rst_err",  32'(r_err), 32'd0);
    check("post_rst_start_cond", 32'(start_seen), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
